mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Clock  in  1  sole clock; all state updates on rising edge.
REQ-002 Reset  in  1  reset, synchronous, active-high.
REQ-003 rs2  in  32  store data from EX/MEM register.
REQ-004 rd  in  5  destination register index.
REQ-005 result  in  32  ALU result; byte address when Rmem or Wmem is high.
REQ-006 Wmem, Rmem, Wreg  in  1 each  store, load and register-write controls.
REQ-007 func3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 dmem_req  out  1  memory request.
REQ-009 dmem_we  out  1  1 = write.
REQ-010 dmem_addr  out  32  word address {result[31:2],2'b00}.
REQ-011 dmem_wdata  out  32  lane-replicated store data.
REQ-012 dmem_be  out  4  byte enables.
REQ-013 dmem_ready  in  1  request accepted this cycle.
REQ-014 dmem_rvalid, dmem_rdata  in  1, 32  read data return.
REQ-015 stall  out  1  upstream holds all inputs stable while high.
REQ-016 MEM_rd, MEM_data, MEM_Wreg, MEM_misalign  out  5, 32, 1, 1  registered MEM/WB outputs.

Function
REQ-017 FSM states IDLE, REQ, WAIT; all outputs in REQ-016 are registers.
REQ-018 Non-memory op (Rmem=Wmem=0): next edge MEM_data=result, MEM_rd=rd, MEM_Wreg=Wreg; stall=0; latency 1 cycle.
REQ-019 Wmem=1 overrides Rmem: operation treated as store.
REQ-020 Misaligned (H with addr[0]=1; W with addr[1:0]!=0) or illegal func3 on a memory op: no dmem_req, stall=0, next edge MEM_misalign=1, MEM_Wreg=0, MEM_data=result.
REQ-021 IDLE, legal memory op: dmem_req=1 combinationally; if dmem_ready=0 go to REQ and hold req/addr/we/be/wdata until ready.
REQ-022 Store accepted (ready=1): complete; next edge MEM_Wreg=0, MEM_data=result; return/stay IDLE.
REQ-023 Load accepted: go to WAIT, dmem_req=0; in WAIT, on dmem_rvalid=1 write extracted data to MEM_data, MEM_Wreg=Wreg, go IDLE.
REQ-024 stall = 1 whenever a legal memory op is present and not completing this cycle (IDLE/REQ without ready, any load before rvalid, WAIT without rvalid).
REQ-025 While stall=1, MEM_Wreg and MEM_misalign registered as 0 (bubble).
REQ-026 SB: be=1<<addr[1:0], wdata={4{rs2[7:0]}}; SH: be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}; SW: be=1111, wdata=rs2.
REQ-027 Load lane select by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unmodified.
REQ-028 MEM_Wreg forced 0 when rd=0.
REQ-029 dmem_rvalid outside WAIT ignored; rvalid never earlier than cycle after acceptance.
REQ-030 dmem_we=Wmem-resolved store flag; be=0000 and we=0 when dmem_req=0.

Reset
REQ-031 Reset=1 at an edge: FSM to IDLE, all REQ-016 outputs to 0.
REQ-032 During Reset=1: dmem_req=0, stall=0, regardless of inputs.
REQ-033 Reset mid-load (REQ or WAIT): transaction abandoned; later stray rvalid ignored, no register write.

Verification
REQ-034 Non-mem: result=0x0000_1234, rd=5, Wreg=1 -> next cycle MEM_data=0x1234, MEM_rd=5, MEM_Wreg=1, stall never high.
REQ-035 SB addr=0x103, rs2=0xAB, ready=1 same cycle -> addr=0x100, be=1000, wdata=0xABABABAB, we=1, stall=0.
REQ-036 LB addr=0x102, ready delayed 2 cycles, rvalid 1 cycle later with rdata=0x0080_0000 -> stall high 4 cycles, then MEM_data=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-037 LW addr=0x102 -> no dmem_req, stall=0, next cycle MEM_misalign=1, MEM_Wreg=0.
REQ-038 Reset asserted in WAIT, rvalid pulsed after release -> MEM_Wreg stays 0, FSM IDLE.
REQ-039 Load with rd=0, Wreg=1 completes -> MEM_Wreg=0, MEM_data holds loaded value.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory request for loads/stores, aligns
// store lanes, extracts load data and registers the MEM/WB outputs.
module mem_stage (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] result,
  input  logic        Wmem,
  input  logic        Rmem,
  input  logic        Wreg,
  input  logic [2:0]  func3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [4:0]  MEM_rd,
  output logic [31:0] MEM_data,
  output logic        MEM_Wreg,
  output logic        MEM_misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        wreg_q, wreg_d;
  logic        mis_q, mis_d;

  logic        is_store, is_mem, size_ok, misal, bad_op, legal_mem;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, rshift, load_data;
  logic        req, ld_done;

  always_comb begin
    is_store = Wmem;
    is_mem   = Wmem | Rmem;
    case (func3)
      3'b000, 3'b001, 3'b010: size_ok = 1'b1;
      3'b100, 3'b101:         size_ok = ~is_store;
      default:                size_ok = 1'b0;
    endcase
    misal     = ((func3[1:0] == 2'b01) && result[0]) ||
                ((func3[1:0] == 2'b10) && (result[1:0] != 2'b00));
    bad_op    = is_mem && (!size_ok || misal);
    legal_mem = is_mem && !bad_op;
  end

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = rs2;
    case (func3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << result[1:0];
        lane_wdata = {4{rs2[7:0]}};
      end
      2'b01: begin
        lane_be    = result[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{rs2[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = rs2;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then size/extend.
  always_comb begin
    rshift = dmem_rdata >> {result[1:0], 3'b000};
    case (func3)
      3'b000:  load_data = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_data = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_data = {24'h000000, rshift[7:0]};
      3'b101:  load_data = {16'h0000, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    ld_done = 1'b0;
    if (!Reset) begin
      case (state_q)
        S_IDLE: begin
          if (legal_mem) begin
            req = 1'b1;
            if (!dmem_ready) begin
              state_d = S_REQ;
              stall   = 1'b1;
            end else if (!is_store) begin
              state_d = S_WAIT;
              stall   = 1'b1;
            end
          end
        end
        S_REQ: begin
          req   = 1'b1;
          stall = 1'b1;
          if (dmem_ready) begin
            if (is_store) begin
              state_d = S_IDLE;
              stall   = 1'b0;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            ld_done = 1'b1;
            state_d = S_IDLE;
          end else begin
            stall = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Stalled cycles hold data/rd and register a bubble on the control bits.
  always_comb begin
    rd_d   = rd_q;
    data_d = data_q;
    wreg_d = 1'b0;
    mis_d  = 1'b0;
    if (!stall) begin
      rd_d = rd;
      if (ld_done) begin
        data_d = load_data;
        wreg_d = Wreg && (rd != 5'd0);
      end else begin
        data_d = result;
        wreg_d = !is_mem && Wreg && (rd != 5'd0);
        mis_d  = bad_op;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      data_q  <= '0;
      wreg_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      wreg_q  <= wreg_d;
      mis_q   <= mis_d;
    end
  end

  assign dmem_req     = req;
  assign dmem_we      = req & is_store;
  assign dmem_be      = req ? lane_be : 4'b0000;
  assign dmem_addr    = {result[31:2], 2'b00};
  assign dmem_wdata   = lane_wdata;
  assign MEM_rd       = rd_q;
  assign MEM_data     = data_q;
  assign MEM_Wreg     = wreg_q;
  assign MEM_misalign = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: per-scenario tasks, expected MEM/WB
// results queued when an op is driven and compared when it retires.
module tb_mem_stage;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] rs2, result, dmem_addr, dmem_wdata, dmem_rdata, MEM_data;
  logic [4:0]  rd, MEM_rd;
  logic        Wmem, Rmem, Wreg, dmem_req, dmem_we, dmem_ready, dmem_rvalid;
  logic        stall, MEM_Wreg, MEM_misalign;
  logic [2:0]  func3;
  logic [3:0]  dmem_be;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [38:0] sbq[$];
  logic [38:0] e;

  mem_stage dut (
    .Clock(Clock), .Reset(Reset), .rs2(rs2), .rd(rd), .result(result),
    .Wmem(Wmem), .Rmem(Rmem), .Wreg(Wreg), .func3(func3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .stall(stall),
    .MEM_rd(MEM_rd), .MEM_data(MEM_data), .MEM_Wreg(MEM_Wreg),
    .MEM_misalign(MEM_misalign)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic set_op(input logic wm, input logic rm, input logic wr,
                        input logic [2:0] f3, input logic [31:0] res,
                        input logic [31:0] r2, input logic [4:0] d);
    Wmem = wm; Rmem = rm; Wreg = wr; func3 = f3; result = res; rs2 = r2; rd = d;
  endtask

  task automatic test_reset();
    Reset = 1'b1; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    set_op(1'b0, 1'b1, 1'b1, 3'b010, 32'h200, 32'h0, 5'd3);
    repeat (2) @(posedge Clock);
    @(negedge Clock); #1;
    total++;
    if ({dmem_req, stall, dmem_we, dmem_be} !== 7'b0) $display("FAIL reset_comb: req,stall,we,be=%b expected 0000000", {dmem_req, stall, dmem_we, dmem_be});
    else passed++;
    @(posedge Clock); #1;
    total++;
    if ({MEM_data, MEM_rd, MEM_Wreg, MEM_misalign} !== 39'h0) $display("FAIL reset_regs: got %h expected 0", {MEM_data, MEM_rd, MEM_Wreg, MEM_misalign});
    else passed++;
  endtask

  task automatic test_nonmem();
    logic [31:0] res_t [4] = '{32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_0055, 32'h0000_0077};
    logic [4:0]  rd_t  [4] = '{5'd5, 5'd31, 5'd0, 5'd9};
    logic        wr_t  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        ew    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      Reset = 1'b0;
      set_op(1'b0, 1'b0, wr_t[i], 3'b010, res_t[i], 32'hFFFF_FFFF, rd_t[i]);
      sbq.push_back({res_t[i], rd_t[i], ew[i], 1'b0});
      #1;
      total++;
      if ({stall, dmem_req, dmem_be} !== 6'b0) $display("FAIL nonmem_comb[%0d]: stall,req,be=%b expected 000000", i, {stall, dmem_req, dmem_be});
      else passed++;
      @(posedge Clock); #1;
      e = sbq.pop_front();
      total++;
      if ({MEM_data, MEM_rd, MEM_Wreg, MEM_misalign} !== e) $display("FAIL nonmem_out[%0d]: got %h expected %h", i, {MEM_data, MEM_rd, MEM_Wreg, MEM_misalign}, e);
      else passed++;
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3_t [5] = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b000};
    logic [31:0] ad_t [5] = '{32'h103, 32'h102, 32'h100, 32'h104, 32'h101};
    logic [31:0] r2_t [5] = '{32'h0000_00AB, 32'h1234_CDEF, 32'h1234_CDEF, 32'hCAFE_F00D, 32'h0000_005A};
    logic [3:0]  be_t [5] = '{4'b1000, 4'b1100, 4'b0011, 4'b1111, 4'b0010};
    logic [31:0] wd_t [5] = '{32'hABAB_ABAB, 32'hCDEF_CDEF, 32'hCDEF_CDEF, 32'hCAFE_F00D, 32'h5A5A_5A5A};
    logic [31:0] wa_t [5] = '{32'h100, 32'h100, 32'h100, 32'h104, 32'h100};
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      // entry 3 also raises Rmem: the store must win
      set_op(1'b1, (i == 3), 1'b1, f3_t[i], ad_t[i], r2_t[i], 5'd7);
      dmem_ready = 1'b1;
      sbq.push_back({ad_t[i], 5'd7, 1'b0, 1'b0});
      #1;
      total++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall} !== {1'b1, 1'b1, wa_t[i], be_t[i], wd_t[i], 1'b0})
        $display("FAIL store_bus[%0d]: req,we,addr,be,wdata,stall=%b,%b,%h,%b,%h,%b expected 1,1,%h,%b,%h,0",
                 i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall, wa_t[i], be_t[i], wd_t[i]);
      else passed++;
      @(posedge Clock); #1;
      e = sbq.pop_front();
      total++;
      if ({MEM_data, MEM_rd, MEM_Wreg, MEM_misalign} !== e) $display("FAIL store_out[%0d]: got %h expected %h", i, {MEM_data, MEM_rd, MEM_Wreg, MEM_misalign}, e);
      else passed++;
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_load_stall();
    logic [2:0]  f3_t [2] = '{3'b000, 3'b100};
    logic [31:0] ex_t [2] = '{32'hFFFF_FF80, 32'h0000_0080};
    int unsigned stalls;
    logic        done;
    for (int k = 0; k < 2; k++) begin
      @(negedge Clock);
      set_op(1'b0, 1'b1, 1'b1, f3_t[k], 32'h102, 32'h0, 5'd10);
      sbq.push_back({ex_t[k], 5'd10, 1'b1, 1'b0});
      stalls = 0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        if (c > 0) @(negedge Clock);
        dmem_ready  = (c == 2);
        dmem_rvalid = (c == 1) || (c == 4);
        dmem_rdata  = (c == 1) ? 32'h7F00_0000 : 32'h0080_0000;
        #1;
        if (stall) stalls++;
        else done = 1'b1;
        if (c == 0) begin
          total++;
          if ({dmem_req, dmem_we, dmem_addr, dmem_be} !== {1'b1, 1'b0, 32'h100, 4'b0100}) $display("FAIL load_req[%0d]: req,we,addr,be=%b,%b,%h,%b expected 1,0,00000100,0100", k, dmem_req, dmem_we, dmem_addr, dmem_be);
          else passed++;
        end
        if (c == 3) begin
          total++;
          if ({dmem_req, dmem_be} !== 5'b0) $display("FAIL load_wait_req[%0d]: req,be=%b expected 00000", k, {dmem_req, dmem_be});
          else passed++;
        end
        @(posedge Clock); #1;
        if (c == 1) begin
          total++;
          if ({MEM_Wreg, MEM_misalign} !== 2'b00) $display("FAIL load_bubble[%0d]: Wreg,misalign=%b expected 00", k, {MEM_Wreg, MEM_misalign});
          else passed++;
        end
      end
      dmem_ready = 1'b0; dmem_rvalid = 1'b0;
      total++;
      if (!done || stalls != 4) $display("FAIL load_stall_cycles[%0d]: got %0d (done=%b) expected 4 (done=1)", k, stalls, done);
      else passed++;
      e = sbq.pop_front();
      total++;
      if ({MEM_data, MEM_rd, MEM_Wreg, MEM_misalign} !== e) $display("FAIL load_stall_out[%0d]: got %h expected %h", k, {MEM_data, MEM_rd, MEM_Wreg, MEM_misalign}, e);
      else passed++;
    end
  endtask

  task automatic test_load_lanes();
    logic [2:0]  f3_t [6] = '{3'b001, 3'b101, 3'b010, 3'b000, 3'b100, 3'b000};
    logic [31:0] ad_t [6] = '{32'h102, 32'h100, 32'h104, 32'h101, 32'h103, 32'h100};
    logic [31:0] rv_t [6] = '{32'h8001_1234, 32'h1234_F00D, 32'h89AB_CDEF, 32'h1122_7F44, 32'hC300_0000, 32'h0000_00FE};
    logic [31:0] ex_t [6] = '{32'hFFFF_8001, 32'h0000_F00D, 32'h89AB_CDEF, 32'h0000_007F, 32'h0000_00C3, 32'hFFFF_FFFE};
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      set_op(1'b0, 1'b1, 1'b1, f3_t[i], ad_t[i], 32'h0, 5'd12);
      dmem_ready = 1'b1;
      sbq.push_back({ex_t[i], 5'd12, 1'b1, 1'b0});
      @(posedge Clock);
      @(negedge Clock);
      dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rv_t[i];
      #1;
      total++;
      if (stall !== 1'b0) $display("FAIL lane_done[%0d]: stall=%b expected 0", i, stall);
      else passed++;
      @(posedge Clock); #1;
      dmem_rvalid = 1'b0;
      e = sbq.pop_front();
      total++;
      if ({MEM_data, MEM_rd, MEM_Wreg, MEM_misalign} !== e) $display("FAIL lane_out[%0d]: got %h expected %h", i, {MEM_data, MEM_rd, MEM_Wreg, MEM_misalign}, e);
      else passed++;
    end
  endtask

  task automatic test_misalign();
    logic        wm_t [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3_t [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b110};
    logic [31:0] ad_t [5] = '{32'h102, 32'h101, 32'h101, 32'h100, 32'h200};
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      set_op(wm_t[i], ~wm_t[i], 1'b1, f3_t[i], ad_t[i], 32'h1111_2222, 5'd8);
      dmem_ready = 1'b1;
      sbq.push_back({ad_t[i], 5'd8, 1'b0, 1'b1});
      #1;
      total++;
      if ({dmem_req, dmem_we, dmem_be, stall} !== 7'b0) $display("FAIL misalign_comb[%0d]: req,we,be,stall=%b expected 0000000", i, {dmem_req, dmem_we, dmem_be, stall});
      else passed++;
      @(posedge Clock); #1;
      e = sbq.pop_front();
      total++;
      if ({MEM_data, MEM_rd, MEM_Wreg, MEM_misalign} !== e) $display("FAIL misalign_out[%0d]: got %h expected %h", i, {MEM_data, MEM_rd, MEM_Wreg, MEM_misalign}, e);
      else passed++;
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_reset_wait();
    @(negedge Clock);
    set_op(1'b0, 1'b1, 1'b1, 3'b010, 32'h200, 32'h0, 5'd6);
    dmem_ready = 1'b1;
    @(posedge Clock); #1;
    dmem_ready = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    total++;
    if ({dmem_req, stall} !== 2'b00) $display("FAIL rst_wait_comb: req,stall=%b expected 00", {dmem_req, stall});
    else passed++;
    @(posedge Clock); #1;
    total++;
    if ({MEM_data, MEM_rd, MEM_Wreg, MEM_misalign} !== 39'h0) $display("FAIL rst_wait_regs: got %h expected 0", {MEM_data, MEM_rd, MEM_Wreg, MEM_misalign});
    else passed++;
    @(negedge Clock);
    Reset = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 3'b010, 32'h44, 32'h0, 5'd6);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0BAD;
    sbq.push_back({32'h44, 5'd6, 1'b0, 1'b0});
    #1;
    total++;
    if (stall !== 1'b0) $display("FAIL rst_wait_idle: stall=%b expected 0", stall);
    else passed++;
    @(posedge Clock); #1;
    dmem_rvalid = 1'b0;
    e = sbq.pop_front();
    total++;
    if ({MEM_data, MEM_rd, MEM_Wreg, MEM_misalign} !== e) $display("FAIL rst_wait_stray: got %h expected %h", {MEM_data, MEM_rd, MEM_Wreg, MEM_misalign}, e);
    else passed++;
  endtask

  task automatic test_rd0();
    @(negedge Clock);
    set_op(1'b0, 1'b1, 1'b1, 3'b010, 32'h300, 32'h0, 5'd0);
    dmem_ready = 1'b1;
    sbq.push_back({32'h1357_2468, 5'd0, 1'b0, 1'b0});
    @(posedge Clock);
    @(negedge Clock);
    dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_2468;
    @(posedge Clock); #1;
    dmem_rvalid = 1'b0;
    e = sbq.pop_front();
    total++;
    if ({MEM_data, MEM_rd, MEM_Wreg, MEM_misalign} !== e) $display("FAIL rd0_load: got %h expected %h", {MEM_data, MEM_rd, MEM_Wreg, MEM_misalign}, e);
    else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge Clock);
    set_op(1'b1, 1'b0, 1'b0, 3'b010, 32'h40, 32'h0BAD_F00D, 5'd3);
    dmem_ready = 1'b0;
    sbq.push_back({32'h40, 5'd3, 1'b0, 1'b0});
    #1;
    total++;
    if ({dmem_req, stall} !== 2'b11) $display("FAIL b2b_store_wait: req,stall=%b expected 11", {dmem_req, stall});
    else passed++;
    @(posedge Clock);
    @(negedge Clock);
    dmem_ready = 1'b1;
    #1;
    total++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall} !== {1'b1, 1'b1, 32'h40, 4'b1111, 32'h0BAD_F00D, 1'b0})
      $display("FAIL b2b_store_held: req,we,addr,be,wdata,stall=%b,%b,%h,%b,%h,%b expected 1,1,00000040,1111,0badf00d,0", dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall);
    else passed++;
    @(posedge Clock); #1;
    e = sbq.pop_front();
    total++;
    if ({MEM_data, MEM_rd, MEM_Wreg, MEM_misalign} !== e) $display("FAIL b2b_store_out: got %h expected %h", {MEM_data, MEM_rd, MEM_Wreg, MEM_misalign}, e);
    else passed++;
    @(negedge Clock);
    dmem_ready = 1'b0;
    set_op(1'b0, 1'b0, 1'b1, 3'b000, 32'h99, 32'h0, 5'd4);
    sbq.push_back({32'h99, 5'd4, 1'b1, 1'b0});
    @(posedge Clock); #1;
    e = sbq.pop_front();
    total++;
    if ({MEM_data, MEM_rd, MEM_Wreg, MEM_misalign} !== e) $display("FAIL b2b_alu_out: got %h expected %h", {MEM_data, MEM_rd, MEM_Wreg, MEM_misalign}, e);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_store();
    test_load_stall();
    test_load_lanes();
    test_misalign();
    test_reset_wait();
    test_rd0();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
